uart_crc_ctrl: RTL

Byte-level sequencer for the bit-serial CRC-8 engine used on the UART link. It accepts a frame of bytes from the framer over a valid/ready handshake and clears the engine at frame start. It shifts each byte into the engine one bit per clock and reports the final CRC with a one-cycle done pulse. It sits between the UART TX/RX framers and the CRC engine, which it owns exclusively.

---
 rtl/uart_crc_pkg.sv | 15 +
 rtl/uart_crc_gen.sv | 44 ++++
 rtl/uart_crc_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_crc_pkg.sv
// Shared types and constants for the UART CRC-8 sequencer and its engine.
package uart_crc_pkg;

   localparam int CRC_W = 8;
   localparam logic [CRC_W-1:0] CRC_POL_DEFAULT = 8'h07;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      WAIT_BYTE,
      SHIFT,
      DONE
   } crc_ctrl_state_t;

endpackage

// File: rtl/uart_crc_gen.sv
// Bit-serial CRC engine: one message bit per enabled clock, MSB-first polynomial
// division with implicit x^8 term. Initialize has priority over enable.
module uart_crc_gen
   import uart_crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] CRC_POL = CRC_POL_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             init_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic [CRC_W-1:0] crc_o
);

   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_d;

   // Next CRC value: clear on init, otherwise one division step when enabled.
   always_comb begin
      crc_d = crc_q;
      if (init_i) begin
         crc_d = '0;
      end else if (en_i) begin
         if (crc_q[CRC_W-1] ^ bit_i) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ CRC_POL;
         end else begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0};
         end
      end
   end

   // CRC register with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/uart_crc_ctrl.sv
// Byte-level sequencer feeding the bit-serial CRC-8 engine: accepts a frame of
// bytes over valid/ready, serialises each byte over 8 cycles and pulses
// crc_valid_o once the byte marked last has been absorbed.
module uart_crc_ctrl
   import uart_crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] CRC_POL   = CRC_POL_DEFAULT,
   parameter bit               LSB_FIRST = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_i,
   input  logic             last_i,
   output logic             byte_ready_o,
   output logic             busy_o,
   output logic             crc_valid_o,
   output logic [CRC_W-1:0] crc_o
);

   crc_ctrl_state_t state_q, state_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            last_q, last_d;

   logic            eng_init;
   logic            eng_en;
   logic            eng_bit;

   // Moore-decoded outputs and engine controls.
   assign byte_ready_o = (state_q == WAIT_BYTE);
   assign busy_o       = (state_q != IDLE);
   assign crc_valid_o  = (state_q == DONE);
   assign eng_init     = (state_q == INIT);
   assign eng_en       = (state_q == SHIFT);
   assign eng_bit      = LSB_FIRST ? shreg_q[0] : shreg_q[7];

   // Next-state logic; abort overrides every other input.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_i) state_d = INIT;
            end
            INIT: begin
               state_d = WAIT_BYTE;
            end
            WAIT_BYTE: begin
               if (byte_valid_i) begin
                  shreg_d = byte_i;
                  last_d  = last_i;
                  cnt_d   = 3'd7;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               shreg_d = LSB_FIRST ? {1'b0, shreg_q[7:1]} : {shreg_q[6:0], 1'b0};
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q == 3'd0) begin
                  state_d = last_q ? DONE : WAIT_BYTE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, shift register, counter and last flag with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   uart_crc_gen #(
      .CRC_POL (CRC_POL)
   ) u_crc_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .init_i (eng_init),
      .en_i   (eng_en),
      .bit_i  (eng_bit),
      .crc_o  (crc_o)
   );

endmodule
